// File: rtl/fir_stream_pkg.sv
// Shared definitions for the FIR output stream sink and its helpers.
//   - state_e    : sink FSM states
//   - FIR_OUT_W  : FIR result beat width
//   - KEEP_W     : byte-enable width for FIR_OUT_W
//   - default window length and backpressure pattern constants
package fir_stream_pkg;

  localparam int FIR_OUT_W         = 32;
  localparam int KEEP_W            = FIR_OUT_W / 8;
  localparam int WIN_LEN_DEF       = 40;
  localparam int STALL_PERIOD_DEF  = 16;
  localparam int STALL_LEN_DEF     = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    REPORT  = 2'd2
  } state_e;

endpackage

// File: rtl/axis_ready_shaper.sv
// Backpressure shaper for stream sinks: a free-running stall counter that
// forces ready low for the last STALL_LEN cycles of every STALL_PERIOD.
// Ports:
//   clk, reset  : clock, asynchronous active-low reset
//   run         : sink is able to take beats (registered by the caller)
//   stall_en    : apply the backpressure pattern
//   ready       : run gated by the stall pattern
module axis_ready_shaper #(
  parameter int STALL_PERIOD = 16,
  parameter int STALL_LEN    = 2,
  parameter int CNT_W        = $clog2(STALL_PERIOD)
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic stall_en,
  output logic ready
);

  logic [CNT_W-1:0] stall_cnt;
  logic             stall_active;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (stall_cnt == CNT_W'(STALL_PERIOD - 1)) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // One extra bit so STALL_LEN==0 (threshold == STALL_PERIOD) never stalls.
  assign stall_active = stall_en &&
                        ({1'b0, stall_cnt} >= (CNT_W+1)'(STALL_PERIOD - STALL_LEN));
  assign ready        = run && !stall_active;

endmodule

// File: rtl/fir_stream_sink.sv
// AXI-Stream sink for the FIR result stream. Reduces each window of up to
// WIN_LEN beats to signed min/max and rising zero-crossing count, and
// publishes the results with a one-cycle win_valid pulse.
// Handshake: a beat is transferred on a rising edge where s_axis_tvalid and
// s_axis_tready are both high; tready comes from registers only and never
// looks at tvalid; the upstream holds tdata/tkeep/tlast while tready is low.
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   s_axis_*            : slave stream (tdata, tkeep, tlast, tvalid, tready)
//   stall_en            : enable the periodic backpressure pattern
//   win_valid           : one-cycle pulse, win_* hold the closed window
//   win_max/min/zc/cnt  : window results; win_short = closed early by tlast
//   beat_cnt            : accepted beats since reset (wraps)
//   err_keep            : sticky, a beat carried tkeep != all-ones
//   dbg_state           : current FSM state
module fir_stream_sink
  import fir_stream_pkg::*;
#(
  parameter int DATA_W       = FIR_OUT_W,
  parameter int WIN_LEN      = WIN_LEN_DEF,
  parameter int STALL_PERIOD = STALL_PERIOD_DEF,
  parameter int STALL_LEN    = STALL_LEN_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic [DATA_W/8-1:0] s_axis_tkeep,
  input  logic                s_axis_tlast,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic                stall_en,
  output logic                win_valid,
  output logic [DATA_W-1:0]   win_max,
  output logic [DATA_W-1:0]   win_min,
  output logic [15:0]         win_zc,
  output logic [15:0]         win_cnt,
  output logic                win_short,
  output logic [31:0]         beat_cnt,
  output logic                err_keep,
  output logic [1:0]          dbg_state
);

  state_e state, state_nxt;

  logic signed [DATA_W-1:0] sample;
  logic signed [DATA_W-1:0] acc_max, acc_min, prev;
  logic signed [DATA_W-1:0] nxt_max, nxt_min;
  logic [15:0]              acc_zc, nxt_zc, idx;
  logic                     prev_valid, crossing, beat, last_idx, close;

  axis_ready_shaper #(
    .STALL_PERIOD (STALL_PERIOD),
    .STALL_LEN    (STALL_LEN)
  ) u_shaper (
    .clk      (clk),
    .reset    (reset),
    .run      (state == COLLECT),
    .stall_en (stall_en),
    .ready    (s_axis_tready)
  );

  assign sample    = $signed(s_axis_tdata);
  assign beat      = s_axis_tvalid && s_axis_tready;
  assign last_idx  = (idx == 16'(WIN_LEN - 1));
  assign close     = beat && (last_idx || s_axis_tlast);
  assign win_valid = (state == REPORT);
  assign dbg_state = state;

  // Running reduction including the current beat; idx==0 restarts it.
  // The previous sample deliberately survives window boundaries.
  assign crossing = prev_valid && prev[DATA_W-1] && !sample[DATA_W-1];
  assign nxt_max  = (idx == 16'd0 || sample > acc_max) ? sample : acc_max;
  assign nxt_min  = (idx == 16'd0 || sample < acc_min) ? sample : acc_min;
  assign nxt_zc   = ((idx == 16'd0) ? 16'd0 : acc_zc) + 16'(crossing);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = COLLECT;
      COLLECT: if (close) state_nxt = REPORT;
      REPORT:  state_nxt = COLLECT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= '0;
      acc_max    <= '0;
      acc_min    <= '0;
      acc_zc     <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
      win_max    <= '0;
      win_min    <= '0;
      win_zc     <= '0;
      win_cnt    <= '0;
      win_short  <= 1'b0;
      beat_cnt   <= '0;
      err_keep   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (beat) begin
        beat_cnt   <= beat_cnt + 32'd1;
        prev       <= sample;
        prev_valid <= 1'b1;
        if (s_axis_tkeep != '1) err_keep <= 1'b1;
        if (close) begin
          idx       <= '0;
          win_max   <= nxt_max;
          win_min   <= nxt_min;
          win_zc    <= nxt_zc;
          win_cnt   <= idx + 16'd1;
          win_short <= s_axis_tlast && !last_idx;
        end else begin
          idx     <= idx + 16'd1;
          acc_max <= nxt_max;
          acc_min <= nxt_min;
          acc_zc  <= nxt_zc;
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_stream_sink.sv
module tb_fir_stream_sink;
  import fir_stream_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] s_axis_tdata = '0;
  logic [3:0]  s_axis_tkeep = 4'hF;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        stall_en = 1'b0;
  logic        win_valid;
  logic [31:0] win_max, win_min;
  logic [15:0] win_zc, win_cnt;
  logic        win_short;
  logic [31:0] beat_cnt;
  logic        err_keep;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  fir_stream_sink dut (
    .clk           (clk),
    .reset         (reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .stall_en      (stall_en),
    .win_valid     (win_valid),
    .win_max       (win_max),
    .win_min       (win_min),
    .win_zc        (win_zc),
    .win_cnt       (win_cnt),
    .win_short     (win_short),
    .beat_cnt      (beat_cnt),
    .err_keep      (err_keep),
    .dbg_state     (dbg_state)
  );

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int unsigned exp_beats = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- vectors ----------------
  // kind: 0 constant base, 1 five -100 then five +100 repeating, 2 ramp base+i
  typedef struct {
    int kind;
    int base;
    int tlast_at;   // beat index carrying tlast, -1 for none
    int exp_max;
    int exp_min;
    int exp_zc;
    int exp_cnt;
    int exp_short;
  } vec_t;

  vec_t vecs[9];

  function automatic int gen(input vec_t v, input int i);
    case (v.kind)
      0:       return v.base;
      1:       return ((i / 5) % 2 == 0) ? -100 : 100;
      default: return v.base + i;
    endcase
  endfunction

  // ---------------- drivers ----------------
  logic wv_after;

  // Called at a negedge; returns at the negedge after the beat was taken.
  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int waitc = 0;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    wv_after      = 1'b0;
    while (!s_axis_tready && waitc < 64) begin
      @(negedge clk);
      waitc++;
    end
    if (waitc >= 64) begin
      chk("beat_accept_timeout", {31'd0, s_axis_tready}, 32'd1);
      s_axis_tvalid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    wv_after = win_valid;
    @(negedge clk);
  endtask

  task automatic run_window(input int k);
    vec_t v;
    int   n;
    logic early;
    logic close_wv;
    v = vecs[k];
    n = (v.tlast_at >= 0) ? v.tlast_at + 1 : 40;
    early = 1'b0;
    close_wv = 1'b0;
    exp_q.push_back(32'(v.exp_max));
    exp_q.push_back(32'(v.exp_min));
    exp_q.push_back(32'(v.exp_zc));
    exp_q.push_back(32'(v.exp_cnt));
    exp_q.push_back(32'(v.exp_short));
    for (int i = 0; i < n; i++) begin
      send_beat(32'(gen(v, i)), 4'hF, (i == v.tlast_at));
      if (i < n - 1) early |= wv_after;
      else           close_wv = wv_after;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    exp_beats += n;
    chk($sformatf("v%0d_no_early_valid", k), {31'd0, early}, 32'd0);
    chk($sformatf("v%0d_valid_latency", k), {31'd0, close_wv}, 32'd1);
    chk($sformatf("v%0d_max", k), win_max, exp_q.pop_front());
    chk($sformatf("v%0d_min", k), win_min, exp_q.pop_front());
    chk($sformatf("v%0d_zc", k), {16'd0, win_zc}, exp_q.pop_front());
    chk($sformatf("v%0d_cnt", k), {16'd0, win_cnt}, exp_q.pop_front());
    chk($sformatf("v%0d_short", k), {31'd0, win_short}, exp_q.pop_front());
    chk($sformatf("v%0d_beat_cnt", k), beat_cnt, exp_beats);
    @(negedge clk);
    chk($sformatf("v%0d_valid_pulse_end", k), {31'd0, win_valid}, 32'd0);
    chk($sformatf("v%0d_max_hold", k), win_max, 32'(v.exp_max));
  endtask

  // ---------------- test ----------------
  initial begin
    int   lows;
    int   run_len;
    int   max_run;
    logic early;
    logic close_wv;

    //             kind base tlast  max   min  zc cnt short
    vecs[0] = '{0, 32'h1000, -1, 32'h1000, 32'h1000, 0, 40, 0};
    vecs[1] = '{1, 0,  -1,  100, -100, 4, 40, 0};
    vecs[2] = '{1, 0,  -1,  100, -100, 4, 40, 0};
    vecs[3] = '{2, -5,  9,    4,   -5, 1, 10, 1};
    vecs[4] = '{2, 1,  -1,   40,    1, 0, 40, 0};
    vecs[5] = '{0, -7, 39,   -7,   -7, 0, 40, 0};
    vecs[6] = '{0, 5,   0,    5,    5, 1,  1, 1};
    vecs[7] = '{2, 100, -1, 139,  100, 0, 40, 0};
    vecs[8] = '{0, 5,  -1,    5,    5, 0, 40, 0};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_tready", {31'd0, s_axis_tready}, 32'd0);
    chk("rst_win_valid", {31'd0, win_valid}, 32'd0);
    chk("rst_beat_cnt", beat_cnt, 32'd0);
    chk("rst_win_max", win_max, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'(IDLE));
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_state", {30'd0, dbg_state}, 32'(COLLECT));

    // table-driven windows, no backpressure
    for (int k = 0; k < 7; k++) run_window(k);
    chk("err_keep_clean", {31'd0, err_keep}, 32'd0);

    // tkeep=0x3 on beat 7: sticky error, results unaffected
    early = 1'b0;
    close_wv = 1'b0;
    for (int i = 0; i < 40; i++) begin
      send_beat(32'h22, (i == 6) ? 4'h3 : 4'hF, 1'b0);
      if (i == 6) chk("err_keep_set", {31'd0, err_keep}, 32'd1);
      if (i < 39) early |= wv_after;
      else        close_wv = wv_after;
    end
    s_axis_tvalid = 1'b0;
    exp_beats += 40;
    chk("keep_no_early_valid", {31'd0, early}, 32'd0);
    chk("keep_valid_latency", {31'd0, close_wv}, 32'd1);
    chk("keep_max", win_max, 32'h22);
    chk("keep_min", win_min, 32'h22);
    chk("keep_cnt", {16'd0, win_cnt}, 32'd40);
    chk("keep_beat_cnt", beat_cnt, exp_beats);
    repeat (3) @(negedge clk);
    chk("err_keep_sticky", {31'd0, err_keep}, 32'd1);

    // backpressure pattern: 2 low cycles out of every 16, back to back
    stall_en = 1'b1;
    lows = 0;
    run_len = 0;
    max_run = 0;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      if (!s_axis_tready) begin
        lows++;
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
    end
    chk("stall_low_cycles", 32'(lows), 32'd4);
    chk("stall_low_run", 32'(max_run), 32'd2);
    run_window(7);
    stall_en = 1'b0;

    // reset mid-window discards the partial window
    for (int i = 0; i < 20; i++) send_beat(32'hFFFF_FFFD, 4'hF, 1'b0);
    s_axis_tvalid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_tready", {31'd0, s_axis_tready}, 32'd0);
    chk("async_rst_beat_cnt", beat_cnt, 32'd0);
    chk("async_rst_err_keep", {31'd0, err_keep}, 32'd0);
    chk("async_rst_win_min", win_min, 32'd0);
    chk("async_rst_win_zc", {16'd0, win_zc}, 32'd0);
    chk("async_rst_win_cnt", {16'd0, win_cnt}, 32'd0);
    chk("async_rst_win_short", {31'd0, win_short}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    exp_beats = 0;
    @(negedge clk);
    run_window(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
